// File: rtl/bus_pkg.sv
// Shared bus widths and the round-robin first-one search used by bus arbiters.
package bus_pkg;

  localparam int BUS_AW  = 32;
  localparam int BUS_DW  = 32;
  localparam int BUS_BEW = 4;
  localparam int MAX_M   = 8;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } rr_sel_t;

  // First set bit of elig[n-1:0] at or above ptr, wrapping back to bit 0.
  function automatic rr_sel_t rr_first(input logic [MAX_M-1:0] elig,
                                       input logic [2:0]       ptr,
                                       input int               n);
    rr_sel_t sel;
    int      j;
    sel = '0;
    for (int k = 0; k < MAX_M; k++) begin
      j = (int'(ptr) + k) % n;
      if (k < n && !sel.valid && elig[3'(j)]) begin
        sel.valid = 1'b1;
        sel.idx   = 3'(j);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of master IDs for outstanding reads; push and pop may coincide.
module arb_id_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [W-1:0]  mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage is not reset; an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one req/ack/resp slave among NUM_M masters,
// routing in-order read responses back to their issuer via an ID FIFO.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_M  = 2,
  parameter int MAX_RD = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_M-1:0]          m_req,
  input  logic [NUM_M-1:0]          m_we,
  input  logic [NUM_M*BUS_AW-1:0]   m_addr,
  input  logic [NUM_M*BUS_BEW-1:0]  m_be,
  input  logic [NUM_M*BUS_DW-1:0]   m_wdata,
  output logic [NUM_M-1:0]          m_ack,
  output logic [NUM_M-1:0]          m_resp,
  output logic [NUM_M*BUS_DW-1:0]   m_rdata,
  output logic                      s_req,
  output logic                      s_we,
  output logic [BUS_AW-1:0]         s_addr,
  output logic [BUS_BEW-1:0]        s_be,
  output logic [BUS_DW-1:0]         s_wdata,
  input  logic                      s_ack,
  input  logic                      s_resp,
  input  logic [BUS_DW-1:0]         s_rdata,
  output logic                      err_unexp_resp
);

  localparam int ID_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  localparam logic [0:0] ST_ARB  = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  logic [0:0]      state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] lock_id;
  logic [NUM_M-1:0] elig;
  rr_sel_t         sel;
  logic            gnt_valid;
  logic [ID_W-1:0] gnt_id;
  logic            fifo_full;
  logic            fifo_empty;
  logic [ID_W-1:0] fifo_head;
  logic            rd_accept;
  logic            resp_valid;

  function automatic logic [ID_W-1:0] inc_wrap(input logic [ID_W-1:0] id);
    return (id == ID_W'(NUM_M - 1)) ? '0 : id + 1'b1;
  endfunction

  // Reads are held back while the ID FIFO is full; writes never are.
  assign elig = m_req & (m_we | {NUM_M{!fifo_full}});

  always_comb begin
    sel = rr_first(8'(elig), 3'(rr_ptr), NUM_M);
    if (state == ST_LOCK) begin
      gnt_valid = m_req[lock_id];
      gnt_id    = lock_id;
    end else begin
      gnt_valid = sel.valid;
      gnt_id    = ID_W'(sel.idx);
    end
  end

  // NOTE: every output gets a default first so no path through the loop can infer a latch.
  always_comb begin
    s_req   = gnt_valid;
    s_we    = 1'b0;
    s_addr  = '0;
    s_be    = '0;
    s_wdata = '0;
    m_ack   = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (gnt_valid && gnt_id == ID_W'(i)) begin
        s_we     = m_we[i];
        s_addr   = m_addr[i*BUS_AW +: BUS_AW];
        s_be     = m_be[i*BUS_BEW +: BUS_BEW];
        s_wdata  = m_wdata[i*BUS_DW +: BUS_DW];
        m_ack[i] = s_ack;
      end
    end
  end

  assign resp_valid = s_resp && !fifo_empty;

  always_comb begin
    m_resp  = '0;
    m_rdata = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (resp_valid && fifo_head == ID_W'(i)) begin
        m_resp[i]                  = 1'b1;
        m_rdata[i*BUS_DW +: BUS_DW] = s_rdata;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_ARB;
      rr_ptr  <= '0;
      lock_id <= '0;
    end else if (state == ST_LOCK) begin
      if (gnt_valid && s_ack) begin
        rr_ptr <= inc_wrap(lock_id);
        state  <= ST_ARB;
      end
    end else begin
      if (gnt_valid && s_ack) begin
        rr_ptr <= inc_wrap(gnt_id);
      end else if (gnt_valid) begin
        lock_id <= gnt_id;
        state   <= ST_LOCK;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)                     err_unexp_resp <= 1'b0;
    else if (s_resp && fifo_empty) err_unexp_resp <= 1'b1;
  end

  assign rd_accept = s_req && s_ack && !s_we;

  arb_id_fifo #(
    .DEPTH (MAX_RD),
    .W     (ID_W)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (rd_accept),
    .push_data (gnt_id),
    .pop       (s_resp),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and randomized check of bus_arbiter against a queue-based reference model.
module tb_bus_arbiter;

  localparam int NUM_M  = 3;
  localparam int MAX_RD = 4;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic [NUM_M-1:0]      m_req, m_we, m_ack, m_resp;
  logic [NUM_M*32-1:0]   m_addr, m_wdata, m_rdata;
  logic [NUM_M*4-1:0]    m_be;
  logic                  s_req, s_we, s_ack, s_resp, err_unexp_resp;
  logic [31:0]           s_addr, s_wdata, s_rdata;
  logic [3:0]            s_be;

  bus_arbiter #(.NUM_M(NUM_M), .MAX_RD(MAX_RD)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_be(m_be), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_resp(m_resp), .m_rdata(m_rdata),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_be(s_be), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_resp(s_resp), .s_rdata(s_rdata),
    .err_unexp_resp(err_unexp_resp)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: round-robin pointer, lock, queue of outstanding read issuers.
  int rr;
  int lock_id;
  bit locked;
  bit err_m;
  int q[$];

  // Pending master transactions, held until acknowledged.
  bit          p_req  [NUM_M];
  bit          p_we   [NUM_M];
  logic [31:0] p_addr [NUM_M];
  logic [31:0] p_wdata[NUM_M];
  logic [3:0]  p_be   [NUM_M];

  logic [NUM_M-1:0]    obs_ack, obs_resp;
  logic [NUM_M*32-1:0] obs_rdata;
  logic                obs_s_req, obs_s_we, obs_err;
  logic [31:0]         obs_s_addr, obs_s_wdata;

  task automatic put(input int i, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    p_req[i] = 1'b1; p_we[i] = we; p_addr[i] = addr; p_wdata[i] = wdata; p_be[i] = 4'hF;
  endtask

  task automatic cycle();
    int                  g;
    int                  j;
    bit                  gv;
    bit                  full;
    logic [NUM_M-1:0]    e_ack, e_resp;
    logic [NUM_M*32-1:0] e_rdata;
    e_ack = '0;
    for (int i = 0; i < NUM_M; i++) begin
      m_req[i]          = p_req[i];
      m_we[i]           = p_req[i] && p_we[i];
      m_addr[i*32+:32]  = p_req[i] ? p_addr[i]  : 32'h0;
      m_wdata[i*32+:32] = p_req[i] ? p_wdata[i] : 32'h0;
      m_be[i*4+:4]      = p_req[i] ? p_be[i]    : 4'h0;
    end
    #2;
    obs_ack = m_ack; obs_resp = m_resp; obs_rdata = m_rdata; obs_err = err_unexp_resp;
    obs_s_req = s_req; obs_s_we = s_we; obs_s_addr = s_addr; obs_s_wdata = s_wdata;
    if (rst_i) begin
      rr = 0; locked = 0; lock_id = 0; err_m = 0; q.delete();
    end else begin
      full = (q.size() == MAX_RD);
      gv = 0; g = 0;
      if (locked) begin
        g = lock_id; gv = p_req[g];
      end else begin
        for (int k = 0; k < NUM_M; k++) begin
          j = (rr + k) % NUM_M;
          if (!gv && p_req[j] && (p_we[j] || !full)) begin gv = 1; g = j; end
        end
      end
      if (gv && s_ack) e_ack[g] = 1'b1;
      e_resp = '0; e_rdata = '0;
      if (s_resp && q.size() > 0) begin
        e_resp[q[0]] = 1'b1;
        e_rdata[q[0]*32+:32] = s_rdata;
      end
      check("s_req",   128'(s_req),   128'(gv));
      check("s_we",    128'(s_we),    128'(gv && p_we[g]));
      check("s_addr",  128'(s_addr),  gv ? 128'(p_addr[g])  : 128'h0);
      check("s_be",    128'(s_be),    gv ? 128'(p_be[g])    : 128'h0);
      check("s_wdata", 128'(s_wdata), gv ? 128'(p_wdata[g]) : 128'h0);
      check("m_ack",   128'(m_ack),   128'(e_ack));
      check("m_resp",  128'(m_resp),  128'(e_resp));
      check("m_rdata", 128'(m_rdata), 128'(e_rdata));
      check("err",     128'(err_unexp_resp), 128'(err_m));
      if (gv && s_ack) begin rr = (g + 1) % NUM_M; locked = 0; end
      else if (gv)     begin locked = 1; lock_id = g; end
      if (s_resp) begin
        if (q.size() == 0) err_m = 1;
        else void'(q.pop_front());
      end
      if (gv && s_ack && !p_we[g]) q.push_back(g);
    end
    for (int i = 0; i < NUM_M; i++) if (e_ack[i]) p_req[i] = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; s_ack = 1'b0; s_resp = 1'b0; s_rdata = '0;
    for (int i = 0; i < NUM_M; i++) p_req[i] = 1'b0;
    cycle();
    rst_i = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NUM_M; i++) begin
      p_req[i] = 0; p_we[i] = 0; p_addr[i] = '0; p_wdata[i] = '0; p_be[i] = '0;
    end
    rst_i = 1'b1; s_ack = 1'b0; s_resp = 1'b0; s_rdata = '0;
    m_req = '0; m_we = '0; m_addr = '0; m_be = '0; m_wdata = '0;
    @(posedge clk_i); #1;
    do_reset();
    cycle();
    check("rst_s_req", 128'(obs_s_req), 128'(0));
    check("rst_err",   128'(obs_err),   128'(0));

    // Single read with one-cycle response
    do_reset();
    put(0, 0, 32'h80, 32'h0); s_ack = 1'b1;
    cycle();
    check("rd_ack0", 128'(obs_ack), 128'(1));
    check("rd_addr", 128'(obs_s_addr), 128'h80);
    s_ack = 1'b0; s_resp = 1'b1; s_rdata = 32'hA5;
    cycle();
    check("rd_resp0", 128'(obs_resp), 128'(1));
    check("rd_data0", 128'(obs_rdata[31:0]), 128'hA5);
    s_resp = 1'b0;

    // Alternating continuous writes
    do_reset();
    s_ack = 1'b1;
    put(0, 1, 32'h100, 32'hD000); put(1, 1, 32'h200, 32'hD100);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("alt_ack", 128'(obs_ack), 128'(1 << (k % 2)));
      check("alt_wd",  128'(obs_s_wdata), 128'(32'hD000 + 32'((k % 2) * 'h100) + 32'(k / 2)));
      put(k % 2, 1, 32'h100 * (k % 2 + 1), 32'hD000 + 32'((k % 2) * 'h100) + 32'(k / 2 + 1));
    end

    // Stall locks the grant on master 1
    do_reset();
    put(1, 1, 32'h44, 32'h1111);
    for (int k = 0; k < 5; k++) begin
      s_ack = (k >= 3);
      if (k == 1) put(0, 1, 32'h40, 32'h0);
      cycle();
      if (k < 3)  check("lock_addr", 128'(obs_s_addr), 128'h44);
      if (k == 3) check("lock_ack1", 128'(obs_ack), 128'(2));
      if (k == 4) check("lock_ack0", 128'(obs_ack), 128'(1));
    end

    // FIFO full blocks reads but not writes
    do_reset();
    s_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin put(k % 2, 0, 32'(k), 32'h0); cycle(); end
    put(1, 0, 32'h10, 32'h0); put(0, 1, 32'h20, 32'h77);
    cycle();
    check("full_wr_ack", 128'(obs_ack), 128'(1));
    check("full_wr_we",  128'(obs_s_we), 128'(1));
    cycle();
    check("full_blk", 128'(obs_s_req), 128'(0));
    s_resp = 1'b1; s_rdata = 32'hCC;
    cycle();
    check("full_resp0", 128'(obs_resp), 128'(1));
    s_resp = 1'b0;
    cycle();
    check("full_rd_ack", 128'(obs_ack), 128'(2));

    // Interleaved responses with simultaneous push and pop
    do_reset();
    s_ack = 1'b1;
    put(1, 0, 32'h8, 32'h0); cycle();
    put(0, 0, 32'hC, 32'h0); cycle();
    s_resp = 1'b1; s_rdata = 32'h11;
    cycle();
    check("il_resp1", 128'(obs_resp), 128'(2));
    check("il_data1", 128'(obs_rdata[63:32]), 128'h11);
    put(0, 0, 32'h10, 32'h0); s_rdata = 32'h22;
    cycle();
    check("il_resp0", 128'(obs_resp), 128'(1));
    check("il_data0", 128'(obs_rdata[31:0]), 128'h22);
    s_rdata = 32'h33;
    cycle();
    check("il_resp0b", 128'(obs_resp), 128'(1));
    s_resp = 1'b0;

    // Unexpected response, then reset clears the flag and rr pointer
    do_reset();
    s_resp = 1'b1; s_rdata = 32'hEE;
    cycle();
    check("ux_noresp", 128'(obs_resp), 128'(0));
    s_resp = 1'b0;
    put(1, 0, 32'h0, 32'h0); s_ack = 1'b1;
    cycle();
    check("ux_err", 128'(obs_err), 128'(1));
    do_reset();
    s_ack = 1'b1;
    put(0, 1, 32'h0, 32'h5); put(1, 1, 32'h4, 32'h6);
    cycle();
    check("ux_clr", 128'(obs_err), 128'(0));
    check("ux_rr0", 128'(obs_ack), 128'(1));
    s_resp = 1'b1;
    cycle();
    s_resp = 1'b0;
    cycle();
    check("ux_post", 128'(obs_err), 128'(1));

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NUM_M; i++) begin
        if (!p_req[i] && $urandom_range(0, 1) == 1) begin
          put(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
          p_be[i] = 4'($urandom_range(0, 15));
        end
      end
      s_ack   = ($urandom_range(0, 3) != 0);
      s_resp  = (q.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 49) == 0);
      s_rdata = $urandom;
      rst_i   = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
